// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
package if_pkg;
   typedef enum logic [1:0] {IDLE, REQ, FULL, DROP} if_state_t;

   localparam logic [31:0] NOP          = 32'h0000_0000;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc_plus4;
   } if_entry_t;
endpackage

// File: rtl/if_queue.sv
// Synchronous FIFO of fetched {inst, pc+4} entries; clear wins over push.
module if_queue
   import if_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  if_entry_t     din_i,
   output logic [CW-1:0] count_o,
   output if_entry_t     head_o
);
   localparam int AW = $clog2(DEPTH);

   if_entry_t     mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_o <= '0;
      end else begin
         if (push_i) wr_ptr <= wr_ptr + AW'(1);
         if (pop_i)  rd_ptr <= rd_ptr + AW'(1);
         count_o <= count_o + CW'(push_i) - CW'(pop_i);
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two; a push into a full
   // queue only happens alongside a pop, which frees the slot being written.
   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i && !rst_i) mem[wr_ptr] <= din_i;
   end

   assign head_o = mem[rd_ptr];
endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with prefetch queue; req/ack memory side, IF/ID side honours stall.
// Optional IF_PERF_CNT_EN adds fetch_cnt_o / drop_cnt_o performance counters.
module if_prefetch
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int          DEPTH    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic        valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc_plus4_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] drop_cnt_o
`endif
);
   localparam int CW = $clog2(DEPTH + 1);

   if_state_t   state, state_nx;
   logic [31:0] fpc, drop_addr, redir_pc;
   logic [CW-1:0] count;
   logic [CW:0]   count_nx;
   logic        push, pop, space;
   if_entry_t   head, din;

   assign redir_pc   = redirect_pc_i & ~32'h3;
   assign valid_o    = (count != '0);
   assign pop        = valid_o & ~stall_i & ~redirect_i;
   assign push       = (state == REQ) & imem_ack_i & ~redirect_i;
   assign count_nx   = redirect_i ? '0 : {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
   assign space      = count_nx < (CW+1)'(DEPTH);

   assign imem_req_o  = (state == REQ) || (state == DROP);
   // A dropped request keeps its original address even though fpc already moved.
   assign imem_addr_o = (state == DROP) ? drop_addr : fpc;
   assign inst_o      = valid_o ? head.inst     : NOP;
   assign pc_plus4_o  = valid_o ? head.pc_plus4 : NOP;

   assign din.inst     = imem_data_i;
   assign din.pc_plus4 = fpc + 32'd4;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start_i && space) state_nx = REQ;
         REQ:  if (imem_ack_i) state_nx = !start_i ? IDLE : (space ? REQ : FULL);
         FULL: if (!start_i) state_nx = IDLE; else if (space) state_nx = REQ;
         DROP: if (imem_ack_i) state_nx = (start_i && space) ? REQ : IDLE;
         default: state_nx = IDLE;
      endcase
      if (redirect_i) begin
         if (imem_req_o && !imem_ack_i) state_nx = DROP;
         else                           state_nx = start_i ? REQ : IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         fpc       <= RESET_PC;
         drop_addr <= RESET_PC;
      end else begin
         state <= state_nx;
         if (redirect_i) fpc <= redir_pc;
         else if (push)  fpc <= fpc + 32'd4;
         if (state == REQ && state_nx == DROP) drop_addr <= fpc;
      end
   end

   if_queue #(.DEPTH(DEPTH), .CW(CW)) u_queue (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (redirect_i),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (din),
      .count_o (count),
      .head_o  (head)
   );

`ifdef IF_PERF_CNT_EN
   logic drop_ack;
   // Discarded acks are those answered in DROP or landing on a redirect cycle.
   assign drop_ack = imem_req_o & imem_ack_i & ((state == DROP) | redirect_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_cnt_o <= '0;
         drop_cnt_o  <= '0;
      end else begin
         fetch_cnt_o <= fetch_cnt_o + 32'(push);
         drop_cnt_o  <= drop_cnt_o + 32'(drop_ack) + (redirect_i ? 32'(count) : 32'd0);
      end
   end
`endif
endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: memory model returns word = address, scoreboard of expected pops.
module tb_if_prefetch;
   import if_pkg::*;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, start = 1'b0, redirect = 1'b0, stall = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req, imem_ack, valid;
   logic [31:0] imem_addr, imem_data, inst, pc4;
   logic        start2 = 1'b0, req2, valid2;
   logic [31:0] addr2, inst2, pc42;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt, drop_cnt, fetch_cnt2, drop_cnt2;
`endif

   int lat = 0, wait_cnt = 0;
   int n_checks = 0, n_pass = 0;
   int live_acks = 0, stale_acks = 0;

   assign imem_ack  = imem_req && (wait_cnt >= lat);
   assign imem_data = imem_addr;
   always @(posedge clk) wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

   if_prefetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .redirect_i(redirect),
      .redirect_pc_i(redirect_pc), .stall_i(stall),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_ack_i(imem_ack), .imem_data_i(imem_data),
      .valid_o(valid), .inst_o(inst), .pc_plus4_o(pc4)
`ifdef IF_PERF_CNT_EN
      , .fetch_cnt_o(fetch_cnt), .drop_cnt_o(drop_cnt)
`endif
   );

   if_prefetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
      .clk_i(clk), .rst_i(rst), .start_i(start2), .redirect_i(1'b0),
      .redirect_pc_i(32'h0), .stall_i(1'b0),
      .imem_req_o(req2), .imem_addr_o(addr2),
      .imem_ack_i(req2), .imem_data_i(addr2),
      .valid_o(valid2), .inst_o(inst2), .pc_plus4_o(pc42)
`ifdef IF_PERF_CNT_EN
      , .fetch_cnt_o(fetch_cnt2), .drop_cnt_o(drop_cnt2)
`endif
   );

   typedef struct packed { logic [31:0] inst; logic [31:0] pc4; } exp_t;
   exp_t        sb[$];
   logic [31:0] exp_fetch = '0;

   // Scoreboard: pops compared against the head, live acks pushed in fetch order.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst) begin
         sb.delete();
         exp_fetch = 32'h0;
      end else begin
         if (valid && !stall && !redirect) begin
            n_checks++;
            if (sb.size() == 0)
               $display("FAIL sb_pop: inst_o=%h pc_plus4_o=%h popped, none expected", inst, pc4);
            else begin
               e = sb.pop_front();
               if (inst !== e.inst || pc4 !== e.pc4)
                  $display("FAIL sb_pop: got inst=%h pc4=%h want inst=%h pc4=%h", inst, pc4, e.inst, e.pc4);
               else n_pass++;
            end
         end
         if (redirect) begin
            sb.delete();
            if (imem_req && imem_ack) stale_acks++;
            exp_fetch = {redirect_pc[31:2], 2'b00};
         end else if (imem_req && imem_ack) begin
            if (imem_addr == exp_fetch) begin
               sb.push_back({exp_fetch, exp_fetch + 32'd4});
               exp_fetch = exp_fetch + 32'd4;
               live_acks++;
            end else stale_acks++;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drain();
      bit done = 0;
      start = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         if (!valid && !imem_req) done = 1;
      end
      n_checks++;
      if (!done || sb.size() != 0) $display("FAIL drain: done=%0d sb_left=%0d want 1/0", done, sb.size());
      else n_pass++;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; lat = 0;
      step(); step();
      @(negedge clk);
      n_checks++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid); else n_pass++;
      n_checks++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h want 0", inst); else n_pass++;
      n_checks++; if (pc4 !== 32'h0) $display("FAIL rst_pc4: got %h want 0", pc4); else n_pass++;
      n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
      n_checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", imem_addr); else n_pass++;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b0) $display("FAIL req_early: got %b want 0", imem_req); else n_pass++;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL first_req: got %b/%h want 1/0", imem_req, imem_addr); else n_pass++;
      n_checks++; if (valid !== 1'b0) $display("FAIL valid_early: got %b want 0", valid); else n_pass++;
      @(negedge clk);
      n_checks++; if (valid !== 1'b1 || pc4 !== 32'h4) $display("FAIL first_valid: got %b/%h want 1/4", valid, pc4); else n_pass++;
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc4 = 32'h4;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         exp_pc4 = exp_pc4 + 32'd4;
         n_checks++;
         if (valid !== 1'b1 || pc4 !== exp_pc4) $display("FAIL stream[%0d]: got %b/%h want 1/%h", i, valid, pc4, exp_pc4);
         else n_pass++;
      end
      drain();
   endtask

   task automatic test_stall();
      int live0 = live_acks;
      logic [31:0] head_exp = exp_fetch;
      stall = 1'b1; start = 1'b1; lat = 0;
      for (int i = 0; i < 10; i++) step();
      @(negedge clk);
      n_checks++; if (live_acks - live0 != DEPTH) $display("FAIL stall_pushes: got %0d want %0d", live_acks - live0, DEPTH); else n_pass++;
      n_checks++; if (imem_req !== 1'b0) $display("FAIL stall_req: got %b want 0", imem_req); else n_pass++;
      n_checks++; if (valid !== 1'b1 || inst !== head_exp) $display("FAIL stall_head: got %b/%h want 1/%h", valid, inst, head_exp); else n_pass++;
      step(); stall = 1'b0;
      for (int i = 0; i < 6; i++) step();
      drain();
   endtask

   task automatic test_redirect_wait();
      bit found = 0, saw_valid = 0, moved = 0;
      int st0;
      logic [31:0] old_addr;
      lat = 3; start = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (imem_req && !imem_ack && wait_cnt == 1) found = 1;
      end
      n_checks++; if (!found) $display("FAIL rw_wait: got no pending request want one"); else n_pass++;
      old_addr = imem_addr; st0 = stale_acks;
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      step(); redirect = 1'b0;
      for (int i = 0; i < 20 && !moved; i++) begin
         @(negedge clk);
         if (valid) saw_valid = 1;
         if (imem_req && imem_addr != old_addr) moved = 1;
      end
      n_checks++; if (imem_addr !== 32'h100) $display("FAIL rw_addr: got %h want 100", imem_addr); else n_pass++;
      n_checks++; if (saw_valid) $display("FAIL rw_valid: got valid during drop want 0"); else n_pass++;
      n_checks++; if (stale_acks - st0 != 1) $display("FAIL rw_stale: got %0d want 1", stale_acks - st0); else n_pass++;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (valid) found = 1;
      end
      n_checks++; if (!found || inst !== 32'h100 || pc4 !== 32'h104) $display("FAIL rw_first: got %h/%h want 100/104", inst, pc4); else n_pass++;
      drain();
      lat = 0;
   endtask

   task automatic test_redirect_ack_pop();
      int st0;
      start = 1'b1; lat = 0;
      for (int i = 0; i < 4; i++) step();
      n_checks++; if (!(valid && imem_req && imem_ack)) $display("FAIL rap_pre: got %b%b%b want 111", valid, imem_req, imem_ack); else n_pass++;
      st0 = stale_acks;
      redirect = 1'b1; redirect_pc = 32'h200;
      step(); redirect = 1'b0;
      @(negedge clk);
      n_checks++; if (valid !== 1'b0 || imem_addr !== 32'h200) $display("FAIL rap_clear: got %b/%h want 0/200", valid, imem_addr); else n_pass++;
      @(negedge clk);
      n_checks++; if (valid !== 1'b1 || inst !== 32'h200) $display("FAIL rap_first: got %b/%h want 1/200", valid, inst); else n_pass++;
      n_checks++; if (stale_acks - st0 != 1) $display("FAIL rap_stale: got %0d want 1", stale_acks - st0); else n_pass++;
      drain();
   endtask

   task automatic test_reset_full();
      bit found = 0;
      lat = 2; stall = 1'b1; start = 1'b1;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (valid && !imem_req) found = 1;
      end
      n_checks++; if (!found) $display("FAIL rf_full: got no full state want one"); else n_pass++;
      step(); stall = 1'b0; step(); stall = 1'b1;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_req && valid) found = 1; else step();
      end
      n_checks++; if (!found) $display("FAIL rf_req: got no request while holding want one"); else n_pass++;
      rst = 1'b1;
      step();
      @(negedge clk);
      n_checks++; if (valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL rf_out: got %b/%b want 0/0", valid, imem_req); else n_pass++;
      n_checks++; if (imem_addr !== 32'h0) $display("FAIL rf_fpc: got %h want 0", imem_addr); else n_pass++;
`ifdef IF_PERF_CNT_EN
      n_checks++; if (fetch_cnt !== 32'h0 || drop_cnt !== 32'h0) $display("FAIL rf_cnt: got %h/%h want 0/0", fetch_cnt, drop_cnt); else n_pass++;
`endif
      step(); rst = 1'b0; stall = 1'b0; start = 1'b0; lat = 0;
      step();
   endtask

   task automatic test_wrap();
      logic [31:0] ea [4];
      ea[0] = 32'hFFFF_FFF8; ea[1] = 32'hFFFF_FFFC; ea[2] = 32'h0; ea[3] = 32'h4;
      rst = 1'b1; start = 1'b0; start2 = 1'b1;
      step(); step();
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (req2 !== 1'b1 || addr2 !== ea[k]) $display("FAIL wrap_addr[%0d]: got %b/%h want 1/%h", k, req2, addr2, ea[k]);
         else n_pass++;
         if (k > 0) begin
            n_checks++;
            if (valid2 !== 1'b1 || inst2 !== ea[k-1] || pc42 !== ea[k])
               $display("FAIL wrap_head[%0d]: got %b/%h/%h want 1/%h/%h", k, valid2, inst2, pc42, ea[k-1], ea[k]);
            else n_pass++;
         end
      end
      start2 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_wait();
      test_redirect_ack_pop();
      test_reset_full();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
